// File: rtl/alu_frame_engine.sv
// Byte-framed ALU engine: receives a request frame, executes one ALU operation,
// and returns a checksummed response frame through a ready/valid transmitter.
module alu_frame_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] err_count
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int SW = $clog2(DATA_WIDTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, R_OP, R_A, R_B, R_CHK, EXEC, T_HDR, T_STAT, T_RES, T_CHK
    } state_t;

    state_t                state, state_nx;
    logic [IW-1:0]         idx;
    logic [7:0]            op;
    logic [7:0]            chk_acc;
    logic [DATA_WIDTH-1:0] a, b, res;
    logic [2:0]            status;
    logic [7:0]            tx_chk;
    logic [CW-1:0]         idle_cnt;

    logic                  in_rx, last, timeout;
    logic                  op_valid, alu_ovf, err;
    logic [DATA_WIDTH-1:0] alu_res, rsp_res;
    logic [2:0]            rsp_stat;
    logic [7:0]            rsp_chk;

    assign in_rx   = (state == R_OP) || (state == R_A) || (state == R_B) || (state == R_CHK);
    assign last    = (idx == IW'(NB - 1));
    assign timeout = in_rx && !rx_valid && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        op_valid = 1'b1;
        case (op[5:0])
            6'h20: begin
                alu_res = a + b;
                alu_ovf = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (alu_res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            6'h22: begin
                alu_res = a - b;
                alu_ovf = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (alu_res[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
            end
            6'h24:   alu_res = a & b;
            6'h25:   alu_res = a | b;
            6'h26:   alu_res = a ^ b;
            6'h27:   alu_res = ~(a | b);
            6'h02:   alu_res = a >> b[SW-1:0];
            6'h03:   alu_res = $unsigned($signed(a) >>> b[SW-1:0]);
            default: op_valid = 1'b0;
        endcase

        // The running XOR includes the received CHK byte, so a good frame leaves zero.
        err      = !op_valid || (op[7:6] != 2'b00) || (chk_acc != 8'h00);
        rsp_res  = err ? '0 : alu_res;
        rsp_stat = {err, alu_ovf && !err, !err && (alu_res == '0)};
        rsp_chk  = {5'b0, rsp_stat};
        for (int unsigned i = 0; i < NB; i++) begin
            rsp_chk = rsp_chk ^ rsp_res[8*i +: 8];
        end
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            IDLE:   if (rx_valid && rx_data == 8'hA5) state_nx = R_OP;
            R_OP:   if (rx_valid) state_nx = R_A;
            R_A:    if (rx_valid && last) state_nx = R_B;
            R_B:    if (rx_valid && last) state_nx = R_CHK;
            R_CHK:  if (rx_valid) state_nx = EXEC;
            EXEC:   state_nx = T_HDR;
            T_HDR: begin
                tx_valid = 1'b1;
                tx_data  = 8'h5A;
                if (tx_ready) state_nx = T_STAT;
            end
            T_STAT: begin
                tx_valid = 1'b1;
                tx_data  = {5'b0, status};
                if (tx_ready) state_nx = T_RES;
            end
            T_RES: begin
                tx_valid = 1'b1;
                tx_data  = 8'(res >> {idx, 3'b000});
                if (tx_ready && last) state_nx = T_CHK;
            end
            T_CHK: begin
                tx_valid = 1'b1;
                tx_data  = tx_chk;
                if (tx_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (timeout) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            op        <= '0;
            chk_acc   <= '0;
            a         <= '0;
            b         <= '0;
            res       <= '0;
            status    <= '0;
            tx_chk    <= '0;
            idle_cnt  <= '0;
            err_count <= '0;
        end else begin
            state    <= state_nx;
            idle_cnt <= (in_rx && !rx_valid) ? idle_cnt + 1'b1 : '0;

            if (((state == EXEC) && err) || timeout) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end

            case (state)
                IDLE: if (rx_valid && rx_data == 8'hA5) begin
                    chk_acc <= '0;
                    idx     <= '0;
                end
                R_OP: if (rx_valid) begin
                    op      <= rx_data;
                    chk_acc <= chk_acc ^ rx_data;
                end
                R_A: if (rx_valid) begin
                    a[8*int'(idx) +: 8] <= rx_data;
                    chk_acc <= chk_acc ^ rx_data;
                    idx     <= last ? '0 : idx + 1'b1;
                end
                R_B: if (rx_valid) begin
                    b[8*int'(idx) +: 8] <= rx_data;
                    chk_acc <= chk_acc ^ rx_data;
                    idx     <= last ? '0 : idx + 1'b1;
                end
                R_CHK: if (rx_valid) chk_acc <= chk_acc ^ rx_data;
                EXEC: begin
                    res    <= rsp_res;
                    status <= rsp_stat;
                    tx_chk <= rsp_chk;
                end
                T_RES: if (tx_ready) idx <= last ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_frame_engine.sv
// Scoreboard bench for alu_frame_engine: an 8-bit instance (short timeout) and a 16-bit instance.
module tb_alu_frame_engine;
    typedef logic [7:0] frame_t [0:7];

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data8, rx_data16, tx_data8, tx_data16, err8, err16;
    logic       rx_valid8, rx_valid16, tx_valid8, tx_valid16;
    logic       tx_ready8, tx_ready16, busy8, busy16;
    logic [7:0] q8[$], q16[$];
    logic [7:0] e8, e16;
    int         n_cmp  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    alu_frame_engine #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) u_dut8 (
        .clk(clk), .reset(reset), .rx_data(rx_data8), .rx_valid(rx_valid8),
        .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .busy(busy8), .err_count(err8)
    );

    alu_frame_engine #(.DATA_WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .rx_data(rx_data16), .rx_valid(rx_valid16),
        .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
        .busy(busy16), .err_count(err16)
    );

    // Monitors: every accepted byte must match the head of its scoreboard queue.
    always @(negedge clk) begin
        if (tx_valid8 && tx_ready8) begin
            n_cmp++;
            if (q8.size() == 0) begin
                n_fail++;
                $display("FAIL tx8_byte actual=%h required=none", tx_data8);
            end else begin
                e8 = q8.pop_front();
                if (tx_data8 !== e8) begin
                    n_fail++;
                    $display("FAIL tx8_byte actual=%h required=%h", tx_data8, e8);
                end
            end
        end
        if (tx_valid16 && tx_ready16) begin
            n_cmp++;
            if (q16.size() == 0) begin
                n_fail++;
                $display("FAIL tx16_byte actual=%h required=none", tx_data16);
            end else begin
                e16 = q16.pop_front();
                if (tx_data16 !== e16) begin
                    n_fail++;
                    $display("FAIL tx16_byte actual=%h required=%h", tx_data16, e16);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input bit d16, input frame_t f, input int n);
        for (int i = 0; i < n; i++) begin
            if (d16) begin rx_valid16 = 1'b1; rx_data16 = f[i]; end
            else     begin rx_valid8  = 1'b1; rx_data8  = f[i]; end
            step();
        end
        rx_valid8  = 1'b0;
        rx_valid16 = 1'b0;
    endtask

    task automatic expect_rsp(input bit d16, input frame_t e, input int n);
        for (int i = 0; i < n; i++) begin
            if (d16) q16.push_back(e[i]);
            else     q8.push_back(e[i]);
        end
    endtask

    task automatic wait_idle(input bit d16);
        int i;
        i = 0;
        while ((d16 ? busy16 : busy8) && i < 200) begin
            step();
            i++;
        end
        check(d16 ? "idle16" : "idle8", {31'b0, d16 ? busy16 : busy8}, 0);
    endtask

    task automatic run8(input string name, input frame_t rx, input frame_t tx, input logic [7:0] exp_err);
        expect_rsp(0, tx, 4);
        send(0, rx, 5);
        wait_idle(0);
        check({name, "_err"}, {24'b0, err8}, {24'b0, exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        reset = 1'b1;
        rx_valid8 = 1'b0; rx_valid16 = 1'b0;
        rx_data8 = 8'h00; rx_data16 = 8'h00;
        tx_ready8 = 1'b1; tx_ready16 = 1'b1;
        step();
        step();
        check("rst_tx_valid8", {31'b0, tx_valid8}, 0);
        check("rst_tx_data8", {24'b0, tx_data8}, 0);
        check("rst_busy8", {31'b0, busy8}, 0);
        check("rst_err8", {24'b0, err8}, 0);
        check("rst_tx_valid16", {31'b0, tx_valid16}, 0);
        reset = 1'b0;
        step();

        send(0, '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
        check("junk_busy", {31'b0, busy8}, 0);

        run8("add_ovf", '{8'hA5, 8'h20, 8'h7F, 8'h01, 8'h5E, 8'h00, 8'h00, 8'h00},
                        '{8'h5A, 8'h02, 8'h80, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd0);
        run8("sub_zero", '{8'hA5, 8'h22, 8'h05, 8'h05, 8'h22, 8'h00, 8'h00, 8'h00},
                         '{8'h5A, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd0);
        run8("bad_chk", '{8'hA5, 8'h24, 8'h0F, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00},
                        '{8'h5A, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd1);
        run8("sra", '{8'hA5, 8'h03, 8'h80, 8'h03, 8'h80, 8'h00, 8'h00, 8'h00},
                    '{8'h5A, 8'h00, 8'hF0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd1);
        run8("srl", '{8'hA5, 8'h02, 8'h80, 8'h03, 8'h81, 8'h00, 8'h00, 8'h00},
                    '{8'h5A, 8'h00, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd1);
        run8("nor", '{8'hA5, 8'h27, 8'h0F, 8'hF0, 8'hD8, 8'h00, 8'h00, 8'h00},
                    '{8'h5A, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd1);
        run8("xor", '{8'hA5, 8'h26, 8'hAA, 8'h55, 8'hD9, 8'h00, 8'h00, 8'h00},
                    '{8'h5A, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd1);
        run8("undef_op", '{8'hA5, 8'h21, 8'h01, 8'h02, 8'h22, 8'h00, 8'h00, 8'h00},
                         '{8'h5A, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd2);
        run8("op_hi_bits", '{8'hA5, 8'h60, 8'h01, 8'h02, 8'h63, 8'h00, 8'h00, 8'h00},
                           '{8'h5A, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd3);
        run8("sub_ovf", '{8'hA5, 8'h22, 8'h80, 8'h01, 8'hA3, 8'h00, 8'h00, 8'h00},
                        '{8'h5A, 8'h02, 8'h7F, 8'h7D, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd3);
        run8("and_a5_data", '{8'hA5, 8'h24, 8'hA5, 8'h0F, 8'h8E, 8'h00, 8'h00, 8'h00},
                            '{8'h5A, 8'h00, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd3);

        // Timeout after 16 silent cycles inside a frame
        send(0, '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
        check("to_busy_start", {31'b0, busy8}, 1);
        repeat (15) step();
        check("to_busy_16th", {31'b0, busy8}, 1);
        step();
        check("to_busy_fall", {31'b0, busy8}, 0);
        check("to_err", {24'b0, err8}, 4);
        run8("after_to", '{8'hA5, 8'h20, 8'h7F, 8'h01, 8'h5E, 8'h00, 8'h00, 8'h00},
                         '{8'h5A, 8'h02, 8'h80, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00}, 8'd4);

        // 16-bit frame with exact header latency
        expect_rsp(1, '{8'h5A, 8'h00, 8'h35, 8'h12, 8'h27, 8'h00, 8'h00, 8'h00}, 5);
        send(1, '{8'hA5, 8'h20, 8'h34, 8'h12, 8'h01, 8'h00, 8'h07, 8'h00}, 7);
        check("lat_exec_no_valid", {31'b0, tx_valid16}, 0);
        step();
        check("lat_hdr_valid", {31'b0, tx_valid16}, 1);
        check("lat_hdr_data", {24'b0, tx_data16}, 32'h5A);
        wait_idle(1);
        check("dw16_err", {24'b0, err16}, 0);

        // Stall in T_RES, then abort with reset
        tx_ready8 = 1'b0;
        expect_rsp(0, '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
        send(0, '{8'hA5, 8'h25, 8'h0F, 8'h30, 8'h1A, 8'h00, 8'h00, 8'h00}, 5);
        for (int k = 0; k < 2; k++) begin
            i = 0;
            while (!tx_valid8 && i < 20) begin
                step();
                i++;
            end
            check("stall_hs_valid", {31'b0, tx_valid8}, 1);
            tx_ready8 = 1'b1;
            step();
            tx_ready8 = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            check("stall_valid", {31'b0, tx_valid8}, 1);
            check("stall_data", {24'b0, tx_data8}, 32'h3F);
            step();
        end
        reset = 1'b1;
        step();
        check("abort_tx_valid", {31'b0, tx_valid8}, 0);
        check("abort_busy", {31'b0, busy8}, 0);
        check("abort_err", {24'b0, err8}, 0);
        reset = 1'b0;
        tx_ready8 = 1'b1;
        repeat (20) step();
        check("abort_stays_idle", {31'b0, busy8}, 0);

        check("q8_drained", q8.size(), 0);
        check("q16_drained", q16.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
